// File: rtl/riscv_defines.sv
// Shared definitions for the DIFT tag check path.
// Provides the check-class width and encodings, the default TCR width,
// and the state type of the tag check unit FSM.
package riscv_defines;

  localparam int unsigned CHK_CLASS_WIDTH = 3;

  localparam logic [CHK_CLASS_WIDTH-1:0] CHK_JUMP       = 3'd0;
  localparam logic [CHK_CLASS_WIDTH-1:0] CHK_BRANCH     = 3'd1;
  localparam logic [CHK_CLASS_WIDTH-1:0] CHK_LOAD_ADDR  = 3'd2;
  localparam logic [CHK_CLASS_WIDTH-1:0] CHK_STORE_ADDR = 3'd3;
  localparam logic [CHK_CLASS_WIDTH-1:0] CHK_STORE_DATA = 3'd4;
  localparam logic [CHK_CLASS_WIDTH-1:0] CHK_EXEC_PC    = 3'd5;

  // One check-enable bit per class.
  localparam int unsigned TCR_WIDTH = 6;

  typedef enum logic [1:0] {
    TCS_IDLE  = 2'd0,
    TCS_REQ   = 2'd1,
    TCS_DRAIN = 2'd2
  } tag_chk_state_e;

endpackage

// File: rtl/riscv_tag_check_policy.sv
// Combinational tag check policy: selects the source tag relevant to the
// check class and gates it with the class enable bit from the TCR.
// Ports:
//   chk_class_i - check class (CHK_*), classes 6/7 never hit
//   tag_a_i     - rs1 tag
//   tag_b_i     - rs2 tag
//   tag_pc_i    - PC tag
//   tcr_i       - TCR enable bits, indexed by class
//   hit_o       - selected tag is set and its class is enabled
module riscv_tag_check_policy
  import riscv_defines::*;
#(
  parameter int unsigned TCR_WIDTH = riscv_defines::TCR_WIDTH
) (
  input  logic [CHK_CLASS_WIDTH-1:0] chk_class_i,
  input  logic                       tag_a_i,
  input  logic                       tag_b_i,
  input  logic                       tag_pc_i,
  input  logic [TCR_WIDTH-1:0]       tcr_i,
  output logic                       hit_o
);

  always_comb begin
    hit_o = 1'b0;
    case (chk_class_i)
      CHK_JUMP:       hit_o = tcr_i[0] & tag_a_i;
      CHK_BRANCH:     hit_o = tcr_i[1] & (tag_a_i | tag_b_i);
      CHK_LOAD_ADDR:  hit_o = tcr_i[2] & tag_a_i;
      CHK_STORE_ADDR: hit_o = tcr_i[3] & tag_a_i;
      CHK_STORE_DATA: hit_o = tcr_i[4] & tag_b_i;
      CHK_EXEC_PC:    hit_o = tcr_i[5] & tag_pc_i;
      default:        hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/riscv_tag_check_unit.sv
// DIFT tag check unit (EX stage). Checks source tags of security-sensitive
// operations against the TCR policy; on a violation it captures class and
// PC, raises a registered exception request held until acknowledged, then
// stalls new checks for DRAIN_CYCLES cycles. Counts violations (saturating).
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   check_valid_i     - checkable operation presented
//   check_ready_o     - unit accepts checks (low stalls EX)
//   check_class_i     - check class
//   tag_a_i/tag_b_i/tag_pc_i - rs1/rs2/PC tags
//   pc_i              - PC of checked instruction
//   tcr_i             - TCR enable bits
//   exc_req_o/exc_ack_i - exception request / acknowledge
//   exc_cause_o/exc_pc_o - class and PC of captured violation
//   viol_cnt_o/cnt_clr_i - saturating violation count / clear
module riscv_tag_check_unit
  import riscv_defines::*;
#(
  parameter int unsigned TCR_WIDTH    = riscv_defines::TCR_WIDTH,
  parameter int unsigned CNT_WIDTH    = 8,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       check_valid_i,
  output logic                       check_ready_o,
  input  logic [CHK_CLASS_WIDTH-1:0] check_class_i,
  input  logic                       tag_a_i,
  input  logic                       tag_b_i,
  input  logic                       tag_pc_i,
  input  logic [31:0]                pc_i,
  input  logic [TCR_WIDTH-1:0]       tcr_i,
  output logic                       exc_req_o,
  input  logic                       exc_ack_i,
  output logic [CHK_CLASS_WIDTH-1:0] exc_cause_o,
  output logic [31:0]                exc_pc_o,
  output logic [CNT_WIDTH-1:0]       viol_cnt_o,
  input  logic                       cnt_clr_i
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  tag_chk_state_e             state_q, state_d;
  logic [3:0]                 drain_q, drain_d;
  logic                       exc_req_q, exc_req_d;
  logic [CHK_CLASS_WIDTH-1:0] cause_q, cause_d;
  logic [31:0]                pc_q, pc_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic                       policy_hit;
  logic                       violation;

  riscv_tag_check_policy #(
    .TCR_WIDTH(TCR_WIDTH)
  ) u_policy (
    .chk_class_i(check_class_i),
    .tag_a_i    (tag_a_i),
    .tag_b_i    (tag_b_i),
    .tag_pc_i   (tag_pc_i),
    .tcr_i      (tcr_i),
    .hit_o      (policy_hit)
  );

  assign check_ready_o = (state_q == TCS_IDLE);
  assign violation     = check_valid_i & check_ready_o & policy_hit;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;

    case (state_q)
      TCS_IDLE: begin
        if (violation) begin
          state_d = TCS_REQ;
          cause_d = check_class_i;
          pc_d    = pc_i;
        end
      end
      TCS_REQ: begin
        if (exc_ack_i) begin
          state_d = TCS_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      TCS_DRAIN: begin
        if (drain_q == '0) begin
          state_d = TCS_IDLE;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      default: state_d = TCS_IDLE;
    endcase

    // Clear wins over a same-cycle increment; the exception is still raised.
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (violation && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end

    exc_req_d = (state_d == TCS_REQ);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= TCS_IDLE;
      drain_q   <= '0;
      exc_req_q <= 1'b0;
      cause_q   <= '0;
      pc_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      exc_req_q <= exc_req_d;
      cause_q   <= cause_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign exc_req_o   = exc_req_q;
  assign exc_cause_o = cause_q;
  assign exc_pc_o    = pc_q;
  assign viol_cnt_o  = cnt_q;

endmodule

// File: tb/tb_riscv_tag_check_unit.sv
module tb_riscv_tag_check_unit;

  logic        clk;
  logic        rst_n;
  logic        check_valid_i;
  logic        check_ready_o;
  logic [2:0]  check_class_i;
  logic        tag_a_i, tag_b_i, tag_pc_i;
  logic [31:0] pc_i;
  logic [5:0]  tcr_i;
  logic        exc_req_o;
  logic        exc_ack_i;
  logic [2:0]  exc_cause_o;
  logic [31:0] exc_pc_o;
  logic [1:0]  viol_cnt_o;
  logic        cnt_clr_i;

  int n_cmp;
  int n_err;
  int exp_cnt;
  logic [2:0]  exp_cause;
  logic [31:0] exp_pc;

  riscv_tag_check_unit #(
    .TCR_WIDTH   (6),
    .CNT_WIDTH   (2),
    .DRAIN_CYCLES(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .check_valid_i(check_valid_i),
    .check_ready_o(check_ready_o),
    .check_class_i(check_class_i),
    .tag_a_i      (tag_a_i),
    .tag_b_i      (tag_b_i),
    .tag_pc_i     (tag_pc_i),
    .pc_i         (pc_i),
    .tcr_i        (tcr_i),
    .exc_req_o    (exc_req_o),
    .exc_ack_i    (exc_ack_i),
    .exc_cause_o  (exc_cause_o),
    .exc_pc_o     (exc_pc_o),
    .viol_cnt_o   (viol_cnt_o),
    .cnt_clr_i    (cnt_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [2:0]  cls;
    logic        ta;
    logic        tb;
    logic        tpc;
    logic [5:0]  tcr;
    logic [31:0] pc;
    logic        viol;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic present(input logic [2:0] cls, input logic ta, input logic tb,
                         input logic tpc, input logic [5:0] tcr, input logic [31:0] pc);
    check_valid_i = 1'b1;
    check_class_i = cls;
    tag_a_i       = ta;
    tag_b_i       = tb;
    tag_pc_i      = tpc;
    tcr_i         = tcr;
    pc_i          = pc;
  endtask

  task automatic idle_inputs();
    check_valid_i = 1'b0;
    tag_a_i       = 1'b0;
    tag_b_i       = 1'b0;
    tag_pc_i      = 1'b0;
  endtask

  task automatic model_violation(input logic [2:0] cls, input logic [31:0] pc);
    exp_cause = cls;
    exp_pc    = pc;
    if (exp_cnt < 3) exp_cnt++;
  endtask

  // Ack one cycle in REQ, then expect exactly two stall cycles.
  task automatic ack_and_drain();
    exc_ack_i = 1'b1;
    step();
    exc_ack_i = 1'b0;
    chk("drain1_req", 32'(exc_req_o), 32'd0);
    chk("drain1_ready", 32'(check_ready_o), 32'd0);
    chk("drain1_cause_held", 32'(exc_cause_o), 32'(exp_cause));
    chk("drain1_pc_held", exc_pc_o, exp_pc);
    step();
    chk("drain2_ready", 32'(check_ready_o), 32'd0);
    step();
    chk("idle_ready", 32'(check_ready_o), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_cnt = 0;
    exp_cause = '0;
    exp_pc = '0;
    rst_n = 1'b0;
    exc_ack_i = 1'b0;
    cnt_clr_i = 1'b0;
    check_class_i = '0;
    tcr_i = '0;
    pc_i = '0;
    idle_inputs();

    // Reset state
    step();
    step();
    chk("rst_req", 32'(exc_req_o), 32'd0);
    chk("rst_cause", 32'(exc_cause_o), 32'd0);
    chk("rst_pc", exc_pc_o, 32'd0);
    chk("rst_cnt", 32'(viol_cnt_o), 32'd0);
    chk("rst_ready", 32'(check_ready_o), 32'd1);
    rst_n = 1'b1;
    step();

    // TCR all zero: no class may violate even with every tag set
    for (int c = 0; c < 8; c++) begin
      present(3'(c), 1'b1, 1'b1, 1'b1, 6'b000000, 32'h100 + 32'(c));
      step();
      chk("tcr0_no_req", 32'(exc_req_o), 32'd0);
    end
    idle_inputs();
    chk("tcr0_cnt", 32'(viol_cnt_o), 32'd0);

    // Ack outside REQ is ignored
    exc_ack_i = 1'b1;
    step();
    exc_ack_i = 1'b0;
    chk("stray_ack_ready", 32'(check_ready_o), 32'd1);
    chk("stray_ack_req", 32'(exc_req_o), 32'd0);

    // Single-cycle checks in IDLE
    vecs[0]  = '{1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 6'b000001, 32'h0000_1000, 1'b1};
    vecs[1]  = '{1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 6'b111110, 32'h0000_1010, 1'b0};
    vecs[2]  = '{1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 6'b000010, 32'h0000_2000, 1'b1};
    vecs[3]  = '{1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 6'b000010, 32'h0000_2010, 1'b0};
    vecs[4]  = '{1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 6'b000100, 32'h0000_3000, 1'b1};
    vecs[5]  = '{1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 6'b000100, 32'h0000_3010, 1'b0};
    vecs[6]  = '{1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 6'b001000, 32'h0000_4000, 1'b1};
    vecs[7]  = '{1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 6'b010000, 32'h0000_5010, 1'b0};
    vecs[8]  = '{1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 6'b010000, 32'h0000_5000, 1'b1};
    vecs[9]  = '{1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 6'b100000, 32'h0000_6000, 1'b1};
    vecs[10] = '{1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 6'b100000, 32'h0000_6010, 1'b0};
    vecs[11] = '{1'b1, 3'd6, 1'b1, 1'b1, 1'b1, 6'b111111, 32'h0000_7000, 1'b0};
    vecs[12] = '{1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 6'b111111, 32'h0000_7010, 1'b0};
    vecs[13] = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 6'b111111, 32'h0000_8000, 1'b0};

    for (int i = 0; i < 14; i++) begin
      present(vecs[i].cls, vecs[i].ta, vecs[i].tb, vecs[i].tpc, vecs[i].tcr, vecs[i].pc);
      check_valid_i = vecs[i].valid;
      step();
      idle_inputs();
      chk($sformatf("vec%0d_req", i), 32'(exc_req_o), 32'(vecs[i].viol));
      if (vecs[i].viol) model_violation(vecs[i].cls, vecs[i].pc);
      chk($sformatf("vec%0d_cnt", i), 32'(viol_cnt_o), 32'(exp_cnt));
      chk($sformatf("vec%0d_cause", i), 32'(exc_cause_o), 32'(exp_cause));
      chk($sformatf("vec%0d_pc", i), exc_pc_o, exp_pc);
      chk($sformatf("vec%0d_ready", i), 32'(check_ready_o), 32'(!vecs[i].viol));
      if (vecs[i].viol) ack_and_drain();
    end

    // Clear counter
    cnt_clr_i = 1'b1;
    step();
    cnt_clr_i = 1'b0;
    exp_cnt = 0;
    chk("clr_cnt", 32'(viol_cnt_o), 32'd0);

    // Delayed ack (5 REQ cycles) with a second violation offered during REQ
    present(3'd0, 1'b1, 1'b0, 1'b0, 6'b000001, 32'h0000_A000);
    step();
    model_violation(3'd0, 32'h0000_A000);
    present(3'd5, 1'b1, 1'b1, 1'b1, 6'b111111, 32'h0000_B000);
    chk("hold_req1", 32'(exc_req_o), 32'd1);
    for (int k = 2; k <= 5; k++) begin
      if (k == 4) idle_inputs();
      step();
      chk($sformatf("hold_req%0d", k), 32'(exc_req_o), 32'd1);
      chk($sformatf("hold_ready%0d", k), 32'(check_ready_o), 32'd0);
      chk($sformatf("hold_cause%0d", k), 32'(exc_cause_o), 32'd0);
      chk($sformatf("hold_pc%0d", k), exc_pc_o, 32'h0000_A000);
      chk($sformatf("hold_cnt%0d", k), 32'(viol_cnt_o), 32'd1);
    end
    ack_and_drain();
    chk("after_hold_cnt", 32'(viol_cnt_o), 32'd1);

    // Saturation: counter at 1, four more violations -> 3, then clear with a 5th
    for (int v = 0; v < 4; v++) begin
      present(3'd3, 1'b1, 1'b0, 1'b0, 6'b001000, 32'h0000_C000 + 32'(v * 4));
      step();
      idle_inputs();
      model_violation(3'd3, 32'h0000_C000 + 32'(v * 4));
      chk($sformatf("sat%0d_req", v), 32'(exc_req_o), 32'd1);
      chk($sformatf("sat%0d_cnt", v), 32'(viol_cnt_o), 32'(exp_cnt));
      ack_and_drain();
    end
    chk("sat_cnt", 32'(viol_cnt_o), 32'd3);
    present(3'd4, 1'b0, 1'b1, 1'b0, 6'b010000, 32'h0000_D000);
    cnt_clr_i = 1'b1;
    step();
    cnt_clr_i = 1'b0;
    idle_inputs();
    exp_cause = 3'd4;
    exp_pc = 32'h0000_D000;
    exp_cnt = 0;
    chk("clr_vs_inc_cnt", 32'(viol_cnt_o), 32'd0);
    chk("clr_vs_inc_req", 32'(exc_req_o), 32'd1);
    chk("clr_vs_inc_cause", 32'(exc_cause_o), 32'd4);
    chk("clr_vs_inc_pc", exc_pc_o, 32'h0000_D000);
    ack_and_drain();

    // Reset while in REQ
    present(3'd0, 1'b1, 1'b0, 1'b0, 6'b000001, 32'h0000_E000);
    step();
    idle_inputs();
    chk("pre_rst_req", 32'(exc_req_o), 32'd1);
    chk("pre_rst_cnt", 32'(viol_cnt_o), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_req_mid_req", 32'(exc_req_o), 32'd0);
    chk("rst_ready_mid_req", 32'(check_ready_o), 32'd1);
    chk("rst_cnt_mid_req", 32'(viol_cnt_o), 32'd0);
    chk("rst_pc_mid_req", exc_pc_o, 32'd0);

    // Reset while in DRAIN
    present(3'd2, 1'b1, 1'b0, 1'b0, 6'b000100, 32'h0000_F000);
    step();
    idle_inputs();
    exc_ack_i = 1'b1;
    step();
    exc_ack_i = 1'b0;
    chk("pre_rst_drain_ready", 32'(check_ready_o), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_ready_mid_drain", 32'(check_ready_o), 32'd1);
    chk("rst_req_mid_drain", 32'(exc_req_o), 32'd0);
    chk("rst_cause_mid_drain", 32'(exc_cause_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
